// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port, fixed-latency memory between instruction fetch
// and the MEM stage: MEM has priority, IF starvation is bounded, flushed fetches are dropped.
module unified_mem_arbiter #(
    parameter int unsigned LAT        = 2,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    output logic          if_stall,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ready,
    output logic          mem_stall,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          grant_mem;
    logic          grant_if;
    logic          grant_any;
    logic          last_wait;

    logic [CW-1:0] lat_cnt;
    logic [CW-1:0] lat_cnt_nxt;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_cnt_nxt;
    logic          owner_if;
    logic          owner_if_nxt;
    logic          cap_we;
    logic          cap_we_nxt;
    logic          cancel;
    logic          cancel_nxt;
    logic          ram_en_nxt;
    logic          ram_we_nxt;
    logic [AW-1:0] ram_addr_nxt;
    logic [DW-1:0] ram_wdata_nxt;
    logic          if_ready_nxt;
    logic          mem_ready_nxt;
    logic [DW-1:0] if_rdata_nxt;
    logic [DW-1:0] mem_rdata_nxt;

    // Grants only in IDLE; a fetch is never granted in a flush cycle
    assign grant_mem = (state == IDLE) && mem_req &&
                       (!if_req || (starve_cnt < CW'(STARVE_MAX)));
    assign grant_if  = (state == IDLE) && !grant_mem && if_req && !if_flush;
    assign grant_any = grant_mem || grant_if;
    assign last_wait = (state == WAIT) && (lat_cnt == CW'(LAT - 1));

    assign if_stall  = if_req & ~if_ready;
    assign mem_stall = mem_req & ~mem_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (last_wait) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of all registered outputs and bookkeeping
    always_comb begin
        ram_en_nxt     = 1'b0;
        ram_we_nxt     = 1'b0;
        ram_addr_nxt   = ram_addr;
        ram_wdata_nxt  = ram_wdata;
        owner_if_nxt   = owner_if;
        cap_we_nxt     = cap_we;
        lat_cnt_nxt    = '0;
        starve_cnt_nxt = starve_cnt;
        cancel_nxt     = cancel;
        if_ready_nxt   = 1'b0;
        mem_ready_nxt  = 1'b0;
        if_rdata_nxt   = if_rdata;
        mem_rdata_nxt  = mem_rdata;

        if (grant_any) begin
            ram_en_nxt    = 1'b1;
            ram_we_nxt    = grant_mem & mem_we;
            ram_addr_nxt  = grant_mem ? mem_addr : if_addr;
            ram_wdata_nxt = grant_mem ? mem_wdata : '0;
            owner_if_nxt  = grant_if;
            cap_we_nxt    = grant_mem & mem_we;
        end

        // Saturating count of MEM wins while IF is waiting
        if (grant_mem && if_req) begin
            if (starve_cnt < CW'(STARVE_MAX)) starve_cnt_nxt = starve_cnt + CW'(1);
        end else if (grant_any) begin
            starve_cnt_nxt = '0;
        end

        if (state == WAIT) lat_cnt_nxt = lat_cnt + CW'(1);

        if (state == DONE) begin
            cancel_nxt = 1'b0;
        end else if (if_flush && owner_if && (state != IDLE)) begin
            cancel_nxt = 1'b1;
        end

        if (last_wait) begin
            if (owner_if) begin
                if (!cancel && !if_flush) begin
                    if_ready_nxt = 1'b1;
                    if_rdata_nxt = ram_rdata;
                end
            end else begin
                mem_ready_nxt = 1'b1;
                if (!cap_we) mem_rdata_nxt = ram_rdata;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            owner_if   <= 1'b0;
            cap_we     <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            cancel     <= 1'b0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            ram_en     <= ram_en_nxt;
            ram_we     <= ram_we_nxt;
            ram_addr   <= ram_addr_nxt;
            ram_wdata  <= ram_wdata_nxt;
            owner_if   <= owner_if_nxt;
            cap_we     <= cap_we_nxt;
            lat_cnt    <= lat_cnt_nxt;
            starve_cnt <= starve_cnt_nxt;
            cancel     <= cancel_nxt;
            if_ready   <= if_ready_nxt;
            mem_ready  <= mem_ready_nxt;
            if_rdata   <= if_rdata_nxt;
            mem_rdata  <= mem_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (LAT=2, STARVE_MAX=4) with a two-stage
// memory model returning read data exactly LAT cycles after the ram_en cycle.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_stall;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int failures = 0;

    logic [31:0] pipe1 = 32'h0;
    logic [31:0] pipe2 = 32'h0;

    unified_mem_arbiter #(
        .LAT(2), .STARVE_MAX(4), .AW(32), .DW(32)
    ) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Memory contents: 0x40 holds 0xDEADBEEF, every other word is 0xC0DE_xxxx
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | (a & 32'h0000_FFFF);
    endfunction

    always @(posedge clk) begin
        pipe1 <= ram_en ? mem_val(ram_addr) : 32'h0;
        pipe2 <= pipe1;
    end
    assign ram_rdata = pipe2;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        repeat (2) next_cycle();
        #1;
        checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        checks++; if (ram_addr !== 32'h0) begin failures++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
        checks++; if (if_ready !== 1'b0 || mem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", if_ready, mem_ready); end
        checks++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, mem_rdata); end
        resetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_load();
        for (int k = 0; k <= 5; k++) begin
            mem_req = (k <= 4); mem_we = 1'b0; mem_addr = 32'h40;
            #1;
            checks++; if (ram_en !== (k == 1)) begin failures++; $display("FAIL load_ram_en k=%0d got=%b", k, ram_en); end
            checks++; if (mem_ready !== (k == 4)) begin failures++; $display("FAIL load_mem_ready k=%0d got=%b", k, mem_ready); end
            checks++; if (mem_stall !== (k <= 3)) begin failures++; $display("FAIL load_mem_stall k=%0d got=%b", k, mem_stall); end
            if (k == 1) begin
                checks++;
                if (ram_addr !== 32'h40 || ram_we !== 1'b0) begin
                    failures++; $display("FAIL load_issue got addr=%h we=%b exp addr=40 we=0", ram_addr, ram_we);
                end
            end
            next_cycle();
        end
        checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", mem_rdata); end
    endtask

    task automatic test_mem_priority();
        for (int k = 0; k <= 10; k++) begin
            mem_req = (k <= 4); mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h55;
            if_req = (k <= 9); if_addr = 32'h100;
            #1;
            checks++; if (ram_en !== (k == 1 || k == 6)) begin failures++; $display("FAIL prio_ram_en k=%0d got=%b", k, ram_en); end
            checks++; if (mem_ready !== (k == 4)) begin failures++; $display("FAIL prio_mem_ready k=%0d got=%b", k, mem_ready); end
            checks++; if (if_ready !== (k == 9)) begin failures++; $display("FAIL prio_if_ready k=%0d got=%b", k, if_ready); end
            if (k == 1) begin
                checks++;
                if (ram_we !== 1'b1 || ram_addr !== 32'h20 || ram_wdata !== 32'h55) begin
                    failures++; $display("FAIL prio_store_issue got we=%b addr=%h wdata=%h", ram_we, ram_addr, ram_wdata);
                end
            end
            if (k == 6) begin
                checks++;
                if (ram_we !== 1'b0 || ram_addr !== 32'h100) begin
                    failures++; $display("FAIL prio_fetch_issue got we=%b addr=%h exp we=0 addr=100", ram_we, ram_addr);
                end
            end
            next_cycle();
        end
        mem_we = 1'b0;
        checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL prio_mem_rdata_kept got=%h exp=deadbeef", mem_rdata); end
        checks++; if (if_rdata !== 32'hC0DE_0100) begin failures++; $display("FAIL prio_if_rdata got=%h exp=c0de0100", if_rdata); end
    endtask

    task automatic test_starvation();
        logic [31:0] en_addr [8];
        int n = 0;
        for (int k = 0; k <= 29; k++) begin
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
            if_req = (k <= 24); if_addr = 32'h104;
            #1;
            if (ram_en === 1'b1 && n < 8) begin en_addr[n] = ram_addr; n++; end
            checks++; if (if_ready !== (k == 24)) begin failures++; $display("FAIL starve_if_ready k=%0d got=%b", k, if_ready); end
            next_cycle();
        end
        mem_req = 1'b0;
        checks++; if (n !== 6) begin failures++; $display("FAIL starve_grant_count got=%0d exp=6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            logic [31:0] exp_a;
            exp_a = (i == 4) ? 32'h104 : 32'h40;
            checks++; if (en_addr[i] !== exp_a) begin failures++; $display("FAIL starve_order i=%0d got=%h exp=%h", i, en_addr[i], exp_a); end
        end
        checks++; if (if_rdata !== 32'hC0DE_0104) begin failures++; $display("FAIL starve_if_rdata got=%h exp=c0de0104", if_rdata); end
    endtask

    task automatic test_flush();
        for (int k = 0; k <= 10; k++) begin
            mem_req = 1'b0;
            if_req = (k <= 2) || (k >= 5 && k <= 9);
            if_addr = (k <= 2) ? 32'h200 : 32'h300;
            if_flush = (k == 2);
            #1;
            checks++; if (ram_en !== (k == 1 || k == 6)) begin failures++; $display("FAIL flush_ram_en k=%0d got=%b", k, ram_en); end
            checks++; if (if_ready !== (k == 9)) begin failures++; $display("FAIL flush_if_ready k=%0d got=%b", k, if_ready); end
            if (k == 1) begin
                checks++; if (ram_addr !== 32'h200) begin failures++; $display("FAIL flush_addr1 got=%h exp=200", ram_addr); end
            end
            if (k == 6) begin
                checks++; if (ram_addr !== 32'h300) begin failures++; $display("FAIL flush_addr2 got=%h exp=300", ram_addr); end
            end
            if (k == 5) begin
                checks++; if (if_rdata !== 32'hC0DE_0104) begin failures++; $display("FAIL flush_rdata_kept got=%h exp=c0de0104", if_rdata); end
            end
            next_cycle();
        end
        if_flush = 1'b0;
        checks++; if (if_rdata !== 32'hC0DE_0300) begin failures++; $display("FAIL flush_next_rdata got=%h exp=c0de0300", if_rdata); end
    endtask

    task automatic test_reset_in_wait();
        for (int k = 0; k <= 13; k++) begin
            resetn = (k != 2);
            mem_req = (k <= 2) || (k >= 9);
            mem_we = 1'b0; mem_addr = 32'h40; if_req = 1'b0;
            #1;
            checks++; if (mem_ready !== (k == 13)) begin failures++; $display("FAIL rstwait_mem_ready k=%0d got=%b", k, mem_ready); end
            checks++; if (ram_en !== (k == 1 || k == 10)) begin failures++; $display("FAIL rstwait_ram_en k=%0d got=%b", k, ram_en); end
            if (k == 3) begin
                checks++;
                if (mem_rdata !== 32'h0 || if_rdata !== 32'h0 || ram_addr !== 32'h0) begin
                    failures++; $display("FAIL rstwait_cleared got mem=%h if=%h addr=%h exp 0", mem_rdata, if_rdata, ram_addr);
                end
            end
            next_cycle();
        end
        mem_req = 1'b0; resetn = 1'b1;
        checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rstwait_rdata got=%h exp=deadbeef", mem_rdata); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        for (int k = 0; k <= 15; k++) begin
            if_req = (k <= 14); if_addr = 32'h10; mem_req = 1'b0;
            #1;
            if (ram_en === 1'b1) n++;
            checks++; if (ram_en !== (k % 5 == 1)) begin failures++; $display("FAIL b2b_ram_en k=%0d got=%b", k, ram_en); end
            checks++; if (if_ready !== (k % 5 == 4)) begin failures++; $display("FAIL b2b_if_ready k=%0d got=%b", k, if_ready); end
            next_cycle();
        end
        if_req = 1'b0;
        checks++; if (n !== 3) begin failures++; $display("FAIL b2b_issue_count got=%0d exp=3", n); end
        checks++; if (if_rdata !== 32'hC0DE_0010) begin failures++; $display("FAIL b2b_if_rdata got=%h exp=c0de0010", if_rdata); end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_mem_priority();
        test_starvation();
        test_flush();
        test_reset_in_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
